// File: rtl/prng_pkg.sv
// Shared definitions for the PRNG server: FSM states, LFSR geometry and the
// Galois next-state function for x^8+x^6+x^5+x+1.
package prng_pkg;

  localparam int                LFSR_W   = 8;
  localparam logic [LFSR_W-1:0] TAP_MASK = 8'h63;
  localparam logic [LFSR_W-1:0] LOCKOUT  = 8'h01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STEP = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // The all-zero state would be a fixed point, so a step from it escapes to LOCKOUT.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
    logic [LFSR_W-1:0] nxt;
    if (q == '0) begin
      nxt = LOCKOUT;
    end else begin
      nxt = {q[LFSR_W-2:0], 1'b0} ^ (q[LFSR_W-1] ? TAP_MASK : '0);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/lfsr8_core.sv
// 8-bit Galois LFSR register with seed load (zero seed replaced by LOCKOUT)
// and single-step enable; load wins over step.
module lfsr8_core
  import prng_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [LFSR_W-1:0] din,
  input  logic              step,
  output logic [LFSR_W-1:0] q
);

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= LOCKOUT;
    end else if (load) begin
      q <= (din == '0) ? LOCKOUT : din;
    end else if (step) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/prng_server.sv
// Round-robin PRNG server: grants one requester per IDLE visit, steps a shared
// LFSR STEPS times, then holds a valid/ready response. Define
// PRNG_SERVER_STATS_EN to add per-requester saturating grant_cnt counters.
module prng_server
  import prng_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int STEPS = 8,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              seed_load,
  input  logic [7:0]        seed,
  input  logic [NREQ-1:0]   req,
  output logic [NREQ-1:0]   ack,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [7:0]        rsp_data,
  output logic [IDW-1:0]    rsp_id,
  output logic              busy
`ifdef PRNG_SERVER_STATS_EN
  ,
  output logic [NREQ*16-1:0] grant_cnt
`endif
);

  state_t            state;
  logic [7:0]        step_cnt;
  logic [IDW-1:0]    grant_id;
  logic [IDW-1:0]    last_id;
  logic [IDW-1:0]    next_id;
  logic              any_req;
  logic [LFSR_W-1:0] lfsr_q;
  logic              handshake;
  int                idx;

  lfsr8_core u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (state == ST_IDLE && seed_load),
    .din   (seed),
    .step  (state == ST_STEP),
    .q     (lfsr_q)
  );

  // Scan from farthest to nearest after last_id so the nearest requester wins.
  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    next_id = last_id;
    any_req = 1'b0;
    idx     = 0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(last_id) + k) % NREQ;
      if (req[idx]) begin
        next_id = IDW'(idx);
        any_req = 1'b1;
      end
    end
  end

  // NOTE: asynchronous active-low reset clears every control flop immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      step_cnt  <= '0;
      grant_id  <= '0;
      last_id   <= IDW'(NREQ - 1);
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!seed_load && any_req) begin
            grant_id <= next_id;
            step_cnt <= '0;
            busy     <= 1'b1;
            state    <= ST_STEP;
          end
        end
        ST_STEP: begin
          if (step_cnt == 8'(STEPS - 1)) begin
            step_cnt  <= '0;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            step_cnt <= step_cnt + 8'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            last_id   <= grant_id;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  // Response fields are forced to zero whenever no response is offered.
  assign handshake = rsp_valid & rsp_ready;
  assign rsp_data  = rsp_valid ? lfsr_q : '0;
  assign rsp_id    = rsp_valid ? grant_id : '0;
  assign ack       = handshake ? (NREQ'(1) << grant_id) : '0;

`ifdef PRNG_SERVER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (ack[i] && grant_cnt[i*16 +: 16] != 16'hFFFF) begin
          grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: doc/prng_server.md
PRNG_SERVER -- requirements
Module: prng_server

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter STEPS, default 8, LFSR steps per delivered value (1..255).
REQ-003 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port seed_load  input  1  load seed when idle.
REQ-006 SHALL have port seed  input  8  seed value.
REQ-007 SHALL have port req  input  NREQ  level request per requester.
REQ-008 SHALL have port ack  output  NREQ  one-hot, one-cycle pulse on response handshake.
REQ-009 SHALL have port rsp_valid  output  1  response data valid.
REQ-010 SHALL have port rsp_ready  input  1  consumer accepts response.
REQ-011 SHALL have port rsp_data  output  8  random byte.
REQ-012 SHALL have port rsp_id  output  clog2(NREQ)  index of served requester.
REQ-013 SHALL have port busy  output  1  high in any state but IDLE.

Function
REQ-014 SHALL share one 8-bit Galois LFSR, polynomial x^8+x^6+x^5+x+1: next[0]=q[7]; next[1]=q[0]^q[7]; next[5]=q[4]^q[7]; next[6]=q[5]^q[7]; next[2..4]=q[1..3]; next[7]=q[6].
REQ-015 SHALL, on a step from state 0x00, produce 0x01 (lock-out escape).
REQ-016 SHALL implement FSM IDLE -> STEP -> RESP -> IDLE.
REQ-017 SHALL, in IDLE with seed_load=1, load seed (0x00 replaced by 0x01), stay IDLE; seed_load has priority over req.
REQ-018 SHALL ignore seed_load outside IDLE.
REQ-019 SHALL, in IDLE with seed_load=0 and any req bit set, grant round-robin starting at (last served + 1) mod NREQ, latch rsp_id, enter STEP.
REQ-020 SHALL step the LFSR once per cycle in STEP for exactly STEPS cycles, then enter RESP; LFSR holds in IDLE and RESP.
REQ-021 SHALL drive rsp_valid=1 in RESP with rsp_data=LFSR state and rsp_id stable until rsp_ready=1.
REQ-022 SHALL, on rsp_valid&rsp_ready, pulse ack[rsp_id] for that cycle, record rsp_id as last served, return to IDLE.
REQ-023 SHALL give latency: req sampled in IDLE at cycle t -> rsp_valid first high at t+1+STEPS.
REQ-024 SHALL complete a granted transaction even if its req bit drops afterwards.
REQ-025 SHALL drive rsp_data=0, rsp_id=0, ack=0 whenever rsp_valid=0.
REQ-026 SHALL serve at most one request per IDLE visit; at least one idle cycle between responses.

Reset
REQ-027 SHALL on rst_n=0 immediately force: FSM IDLE, LFSR 0x01, step counter 0, last served NREQ-1 (requester 0 first), all outputs 0.
REQ-028 SHALL abort any in-flight transaction on reset mid-STEP or mid-RESP without ack.

Configuration
REQ-029 SHALL, with PRNG_SERVER_STATS_EN defined, add output grant_cnt  NREQ*16  per-requester saturating (0xFFFF) count of completed handshakes, reset 0.
REQ-030 SHALL, without PRNG_SERVER_STATS_EN, have no grant_cnt port and no counter logic.

Structure
REQ-031 SHALL place FSM state enum, LFSR width (8), tap mask 0x63 and lock-out value 0x01 in shared package prng_pkg.
REQ-032 SHALL instantiate sub-module lfsr8_core (ports clk, rst_n, load, din, step, q) holding the LFSR; arbitration and FSM stay in prng_server.

Verification
REQ-033 SHALL cover: seed 0x01, single req[0], STEPS=1 -> rsp_data 0x02, rsp_id 0, ack=0001.
REQ-034 SHALL cover: seed 0x80, STEPS=1 -> rsp_data 0x63; seed 0x00 -> LFSR 0x01; seed 0x01, STEPS=8 -> rsp_data 0x63 at t+9.
REQ-035 SHALL cover: req=1111 held, rsp_ready=1 -> ack order 0,1,2,3,0 after reset.
REQ-036 SHALL cover: rsp_ready low 5 cycles in RESP -> rsp_valid, rsp_data, rsp_id stable, LFSR unchanged, ack 0.
REQ-037 SHALL cover: rst_n low mid-STEP -> same cycle all outputs 0, busy 0; post-reset req[2] -> LFSR restarts from 0x01.
REQ-038 SHALL cover: seed_load with req asserted in IDLE -> seed loaded first, grant next cycle.
